// File: rtl/logic_gate_unit_if.sv
// Operand/result bundle for logic_gate_unit.
//   slave  : block side  - takes switches/op/mode/start, drives opnd_a/opnd_b/result/busy/done
//   master : board side  - drives switches/op/mode/start, observes the outputs
// sw_a/sw_b/op/mode/start may be asynchronous to the block clock.
interface logic_gate_unit_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] sw_a;
  logic [WIDTH-1:0] sw_b;
  logic [2:0]       op;
  logic             mode;
  logic             start;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport slave (
    input  sw_a, sw_b, op, mode, start,
    output opnd_a, opnd_b, result, busy, done
  );

  modport master (
    output sw_a, sw_b, op, mode, start,
    input  opnd_a, opnd_b, result, busy, done
  );
endinterface

// File: rtl/logic_gate_unit.sv
// Bitwise logic gate unit with switch debouncing and an exhaustive operand sweep.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - logic_gate_unit_if.slave: sw_a/sw_b/op/mode/start in (async),
//           opnd_a/opnd_b (applied operands), result (registered gate output),
//           busy (sweep running), done (one-cycle sweep-complete pulse) out
// In idle the operands and op follow the debounced switches. A debounced start rising
// edge with mode=1 runs a sweep over every (a,b) pair, each held STEP_CYCLES cycles.
module logic_gate_unit #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned STEP_CYCLES = 8
) (
  input logic              clk,
  input logic              rst_n,
  logic_gate_unit_if.slave bus
);

  localparam int unsigned NIN = 2 * WIDTH + 5;
  localparam int unsigned IW  = 2 * WIDTH;
  localparam int unsigned DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned SCW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [DCW-1:0] DebLast  = DCW'(DEB_CYCLES - 1);
  localparam logic [SCW-1:0] StepLast = SCW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0]  IdxLast  = '1;

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  // Input synchronisation and per-bit debounce
  logic [NIN-1:0]          raw_in;
  logic [NIN-1:0]          sync1_q, sync2_q;
  logic [NIN-1:0]          deb_q, deb_d;
  logic [NIN-1:0][DCW-1:0] cnt_q, cnt_d;

  assign raw_in = {bus.start, bus.mode, bus.op, bus.sw_b, bus.sw_a};

  // For a single bit, "synced value changed" while it differs from the debounced value
  // implies it now equals the debounced value, so one compare covers both clear rules.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NIN; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DebLast) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  logic [WIDTH-1:0] deb_a, deb_b;
  logic [2:0]       deb_op;
  logic             deb_mode, deb_start;

  assign deb_a     = deb_q[WIDTH-1:0];
  assign deb_b     = deb_q[2*WIDTH-1:WIDTH];
  assign deb_op    = deb_q[2*WIDTH+2:2*WIDTH];
  assign deb_mode  = deb_q[2*WIDTH+3];
  assign deb_start = deb_q[2*WIDTH+4];

  // Sweep control
  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SCW-1:0]   step_q, step_d;
  logic [2:0]       op_q, op_d;
  logic             start_prev_q;
  logic             start_rise;
  logic [WIDTH-1:0] result_q, result_d;

  assign start_rise = deb_start & ~start_prev_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    op_d    = op_q;
    case (state_q)
      StIdle: begin
        if (start_rise && deb_mode) begin
          state_d = StSweep;
          idx_d   = '0;
          step_d  = '0;
          op_d    = deb_op;
        end
      end
      StSweep: begin
        if (!deb_mode) begin
          state_d = StIdle;
        end else if (step_q == StepLast) begin
          step_d = '0;
          if (idx_q == IdxLast) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Applied operands and op: switches in idle, sweep index/latched op otherwise
  logic [WIDTH-1:0] cur_a, cur_b;
  logic [2:0]       act_op;

  always_comb begin
    if (state_q == StIdle) begin
      cur_a  = deb_a;
      cur_b  = deb_b;
      act_op = deb_op;
    end else begin
      cur_a  = idx_q[IW-1:WIDTH];
      cur_b  = idx_q[WIDTH-1:0];
      act_op = op_q;
    end
  end

  always_comb begin
    case (act_op)
      3'd0: result_d = cur_a & cur_b;
      3'd1: result_d = cur_a | cur_b;
      3'd2: result_d = cur_a ^ cur_b;
      3'd3: result_d = ~(cur_a & cur_b);
      3'd4: result_d = ~(cur_a | cur_b);
      3'd5: result_d = ~(cur_a ^ cur_b);
      3'd6: result_d = ~cur_a;
      3'd7: result_d = cur_a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      cnt_q        <= '0;
      state_q      <= StIdle;
      idx_q        <= '0;
      step_q       <= '0;
      op_q         <= '0;
      start_prev_q <= 1'b0;
      result_q     <= '0;
    end else begin
      sync1_q      <= raw_in;
      sync2_q      <= sync1_q;
      deb_q        <= deb_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      step_q       <= step_d;
      op_q         <= op_d;
      start_prev_q <= deb_start;
      result_q     <= result_d;
    end
  end

  assign bus.opnd_a = cur_a;
  assign bus.opnd_b = cur_b;
  assign bus.result = result_q;
  assign bus.busy   = (state_q == StSweep);
  assign bus.done   = (state_q == StDone);

endmodule
